truth_table_checker: RTL and testbench
======================================

// Module: truth_table_checker
// PURPOSE
//  Synthesizable driver/checker for combinational task DUTs. Drives all 2**N_IN input vectors in
//  ascending order, samples the DUT's 1-bit response and compares it with a parameterized truth
//  table. Reports pass/fail, the first failing vector and its expected bit.
//  Sits between the board/sim top and the DUT: vec_out feeds the DUT inputs, and the DUT output
//  returns on dut_in.
// PARAMETERS
//  N_IN    3        DUT input width, 1..8; vec_out[N_IN-1] = MSB (DUT's first operand)
//  EXP     8'h82    expected table, width 2**N_IN; bit i = expected DUT output for vector i
//  SETTLE  1        cycles vec_out is held before sampling; >=1
// PORTS
//  clk       in   1          rising-edge clock
//  rst       in   1          asynchronous, active-high reset
//  start     in   1          run request, level-sampled; honoured only in IDLE or DONE
//  vec_out   out  N_IN       stimulus vector to DUT
//  dut_in    in   1          DUT response
//  busy      out  1          high in DRIVE/CHECK
//  done      out  1          high in DONE, held until restart or reset
//  pass      out  1          valid when done; 1 = no mismatch
//  fail_vec  out  N_IN       first mismatching vector (0 if none)
//  fail_exp  out  1          expected bit at fail_vec
//  err_cnt   out  N_IN+1     mismatch count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; vec_out, busy, done, pass, fail_vec, fail_exp and
//    err_cnt all 0. Reset mid-run aborts with no partial result.
//  - FSM IDLE -> DRIVE -> CHECK -> (DRIVE | DONE); DONE -> DRIVE on start.
//  - IDLE/DONE with start=1 at edge k: vec_out<=0, cnt<=SETTLE-1, done<=0, pass<=0,
//    fail_vec<=0, fail_exp<=0, err_cnt<=0, busy<=1, state<=DRIVE.
//  - DRIVE: vec_out stable; cnt decrements each cycle; at cnt==0 -> CHECK.
//  - CHECK (one cycle): mismatch = (dut_in !== EXP[vec_out]), with X/Z counted as a mismatch
//    in sim.
//    - On mismatch, if this is the first error: fail_vec<=vec_out, fail_exp<=EXP[vec_out].
//    - Last vector (all ones), or early stop: busy<=0, done<=1, pass<=(no mismatch seen),
//      state<=DONE.
//    - Otherwise: vec_out<=vec_out+1, cnt<=SETTLE-1, state<=DRIVE.
//  - Per vector: SETTLE+1 cycles. Full run: done rises after edge k + 2**N_IN*(SETTLE+1).
//  - vec_out is never incremented past all-ones (no wrap). It holds its last value in DONE.
//  - start while busy: ignored. start held high in DONE: a new run begins every time DONE is
//    reached (free-running soak mode).
//  - done/pass/fail_* change only on the edges listed above and are glitch-free registers.
// CONFIGURATION
//  CHECK_ALL_EN defined:
//   - the run always covers all 2**N_IN vectors;
//   - err_cnt increments on every mismatch (saturates at 2**N_IN);
//   - fail_vec/fail_exp keep the FIRST failure.
//  CHECK_ALL_EN undefined:
//   - early stop: the first mismatch goes straight to DONE with pass=0 (mirrors the
//     stop-on-first-assert bench behaviour);
//   - err_cnt is 0 after a pass and 1 after a failure.
// TESTING (bench models the DUT combinationally from vec_out; N_IN=3, EXP=8'h82, SETTLE=1)
//  1. Correct DUT (dut_in=EXP[vec_out]), start pulse at edge 0 -> busy edges 0..15, done=1 and
//     pass=1 after edge 16, err_cnt=0, vec_out=3'b111.
//  2. DUT stuck 0, macro off -> done after edge 4, pass=0, fail_vec=3'b001, fail_exp=1,
//     err_cnt=1.
//  3. DUT stuck 0, CHECK_ALL_EN on -> done after edge 16, pass=0, err_cnt=2, fail_vec=3'b001.
//  4. rst asserted between edges 6 and 7 -> all outputs 0 without waiting for a clock; a later
//     start reproduces scenario 1 exactly.
//  5. start held high through a passing run -> no restart while busy. The first run ends at
//     edge 16; done clears at edge 17 and a second run begins from vec 0.
//  6. dut_in=1'bx at vector 0 -> mismatch: fail_vec=0, fail_exp=0, pass=0.

Source files
------------

// File: rtl/truth_table_checker.sv
// -----------------------------------------------------------------------------
// truth_table_checker
//   Exhaustive driver/checker for a combinational DUT with a 1-bit output.
//   It walks every input vector from 0 up to all-ones and holds each one for
//   SETTLE cycles. It then samples the DUT response for one cycle and compares
//   it with the expected truth table EXP.
//
//   Optional feature macro: CHECK_ALL_EN
//     defined   : always sweep every vector, count every mismatch (saturating),
//                 keep the first failure in fail_vec/fail_exp.
//     undefined : stop at the first mismatch; err_cnt is 0 on pass, 1 on fail.
//
//   Parameters
//     N_IN    DUT input width (1..8); vec_out[N_IN-1] is the MSB
//     EXP     expected table, bit i = expected DUT output for vector i
//     SETTLE  cycles each vector is held before it is sampled (>= 1)
//
//   Ports
//     clk       in   rising-edge clock
//     rst       in   asynchronous active-high reset
//     start     in   run request, level-sampled in IDLE/DONE only
//     vec_out   out  stimulus vector to the DUT
//     dut_in    in   DUT response
//     busy      out  high while a run is in progress
//     done      out  high once a run has finished, until restart or reset
//     pass      out  valid with done; 1 = no mismatch seen
//     fail_vec  out  first mismatching vector (0 if none)
//     fail_exp  out  expected bit at fail_vec
//     err_cnt   out  mismatch count
// -----------------------------------------------------------------------------
module truth_table_checker #(
   parameter int                     N_IN   = 3,
   parameter logic [(1<<N_IN)-1:0]   EXP    = 8'h82,
   parameter int                     SETTLE = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic [N_IN-1:0] vec_out,
   input  logic            dut_in,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN-1:0] fail_vec,
   output logic            fail_exp,
   output logic [N_IN:0]   err_cnt
);

   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);
`ifdef CHECK_ALL_EN
   // Saturation point: one error per vector at most.
   localparam logic [N_IN:0] ERR_MAX = {1'b1, {N_IN{1'b0}}};
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N_IN-1:0] vec_q, vec_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic [N_IN-1:0] fail_vec_q, fail_vec_d;
   logic            fail_exp_q, fail_exp_d;
   logic [N_IN:0]   err_cnt_q, err_cnt_d;

   logic exp_bit;
   logic mismatch;
   logic last_vec;
   logic stop;

   assign exp_bit  = EXP[vec_q];
   // Case inequality so an X/Z response in simulation is flagged as a failure.
   assign mismatch = (dut_in !== exp_bit);
   assign last_vec = (vec_q == {N_IN{1'b1}});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         vec_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         fail_vec_q <= '0;
         fail_exp_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         vec_q      <= vec_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         fail_vec_q <= fail_vec_d;
         fail_exp_q <= fail_exp_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      vec_d      = vec_q;
      busy_d     = busy_q;
      done_d     = done_q;
      pass_d     = pass_q;
      fail_vec_d = fail_vec_q;
      fail_exp_d = fail_exp_q;
      err_cnt_d  = err_cnt_q;
      stop       = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               vec_d      = '0;
               cnt_d      = CNT_INIT;
               done_d     = 1'b0;
               pass_d     = 1'b0;
               fail_vec_d = '0;
               fail_exp_d = 1'b0;
               err_cnt_d  = '0;
               busy_d     = 1'b1;
               state_d    = DRIVE;
            end
         end

         DRIVE: begin
            if (cnt_q == '0) begin
               state_d = CHECK;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         CHECK: begin
            // err_cnt is still zero exactly until the first mismatch is recorded.
            if (mismatch && (err_cnt_q == '0)) begin
               fail_vec_d = vec_q;
               fail_exp_d = exp_bit;
            end
`ifdef CHECK_ALL_EN
            if (mismatch && (err_cnt_q != ERR_MAX)) begin
               err_cnt_d = err_cnt_q + 1'b1;
            end
            stop = last_vec;
`else
            if (mismatch) begin
               err_cnt_d = {{N_IN{1'b0}}, 1'b1};
            end
            stop = last_vec || mismatch;
`endif
            if (stop) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_cnt_q == '0) && !mismatch;
               state_d = DONE;
            end else begin
               vec_d   = vec_q + 1'b1;
               cnt_d   = CNT_INIT;
               state_d = DRIVE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign vec_out  = vec_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign fail_vec = fail_vec_q;
   assign fail_exp = fail_exp_q;
   assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [2:0] vec_out;
   logic       dut_in;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] fail_vec;
   logic       fail_exp;
   logic [3:0] err_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   // DUT model: 0 = correct, 1 = stuck at 0, 2 = X at vector 0, correct elsewhere
   int         mode = 0;
   logic [7:0] exp_tb = 8'h82;

   assign dut_in = (mode == 2 && vec_out == 3'd0) ? 1'bx :
                   (mode == 1) ? 1'b0 : exp_tb[vec_out];

   always #5 clk = ~clk;

   truth_table_checker #(
      .N_IN  (3),
      .EXP   (8'h82),
      .SETTLE(1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .vec_out (vec_out),
      .dut_in  (dut_in),
      .busy    (busy),
      .done    (done),
      .pass    (pass),
      .fail_vec(fail_vec),
      .fail_exp(fail_exp),
      .err_cnt (err_cnt)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Pulse start for one edge; returns 1 time unit after that edge (edge 0).
   task automatic start_run(input logic hold);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      start = 1'b0;
      #2;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: busy=%b done=%b pass=%b want 0 0 0", busy, done, pass);
      end
      n_cmp++;
      if (vec_out !== 3'd0 || fail_vec !== 3'd0 || fail_exp !== 1'b0 || err_cnt !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_data: vec=%b fvec=%b fexp=%b err=%0d want all 0",
                  vec_out, fail_vec, fail_exp, err_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
      tick(2);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_no_start: busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   // Full passing run from a start pulse; shared by the plain and post-reset scenarios.
   task automatic test_pass(input string tag);
      mode = 0;
      start_run(1'b0);
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_edge0: busy=%b done=%b want 1 0", tag, busy, done);
      end
      for (int e = 1; e <= 15; e++) begin
         tick(1);
         n_cmp++;
         if (busy !== 1'b1 || done !== 1'b0 || vec_out !== 3'(e / 2)) begin
            n_fail++;
            $display("FAIL %s_edge%0d: busy=%b done=%b vec=%0d want 1 0 %0d",
                     tag, e, busy, done, vec_out, e / 2);
         end
      end
      tick(1);
      n_cmp++;
      if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_done16: done=%b pass=%b busy=%b want 1 1 0", tag, done, pass, busy);
      end
      n_cmp++;
      if (err_cnt !== 4'd0 || vec_out !== 3'b111 || fail_vec !== 3'd0 || fail_exp !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_result: err=%0d vec=%b fvec=%b fexp=%b want 0 111 000 0",
                  tag, err_cnt, vec_out, fail_vec, fail_exp);
      end
      tick(4);
      n_cmp++;
      if (done !== 1'b1 || pass !== 1'b1 || vec_out !== 3'b111) begin
         n_fail++;
         $display("FAIL %s_hold: done=%b pass=%b vec=%b want 1 1 111", tag, done, pass, vec_out);
      end
   endtask

   task automatic test_stuck0;
      mode = 1;
      start_run(1'b0);
`ifdef CHECK_ALL_EN
      tick(15);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL stuck_edge15: done=%b busy=%b want 0 1", done, busy);
      end
      tick(1);
      n_cmp++;
      if (done !== 1'b1 || pass !== 1'b0 || err_cnt !== 4'd2) begin
         n_fail++;
         $display("FAIL stuck_all_done: done=%b pass=%b err=%0d want 1 0 2", done, pass, err_cnt);
      end
      n_cmp++;
      if (fail_vec !== 3'b001 || fail_exp !== 1'b1 || vec_out !== 3'b111) begin
         n_fail++;
         $display("FAIL stuck_all_first: fvec=%b fexp=%b vec=%b want 001 1 111",
                  fail_vec, fail_exp, vec_out);
      end
`else
      tick(3);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL stuck_edge3: done=%b busy=%b want 0 1", done, busy);
      end
      tick(1);
      n_cmp++;
      if (done !== 1'b1 || pass !== 1'b0 || busy !== 1'b0 || err_cnt !== 4'd1) begin
         n_fail++;
         $display("FAIL stuck_early_done: done=%b pass=%b busy=%b err=%0d want 1 0 0 1",
                  done, pass, busy, err_cnt);
      end
      n_cmp++;
      if (fail_vec !== 3'b001 || fail_exp !== 1'b1 || vec_out !== 3'b001) begin
         n_fail++;
         $display("FAIL stuck_early_first: fvec=%b fexp=%b vec=%b want 001 1 001",
                  fail_vec, fail_exp, vec_out);
      end
`endif
      mode = 0;
   endtask

   task automatic test_reset_mid;
      mode = 0;
      start_run(1'b0);
      tick(6);
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || vec_out !== 3'd0 ||
          fail_vec !== 3'd0 || fail_exp !== 1'b0 || err_cnt !== 4'd0) begin
         n_fail++;
         $display("FAIL async_reset: busy=%b done=%b pass=%b vec=%b fvec=%b fexp=%b err=%0d want all 0",
                  busy, done, pass, vec_out, fail_vec, fail_exp, err_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
      tick(3);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || vec_out !== 3'd0) begin
         n_fail++;
         $display("FAIL after_reset_idle: busy=%b done=%b vec=%b want 0 0 000", busy, done, vec_out);
      end
      test_pass("rerun");
   endtask

   task automatic test_back_to_back;
      mode = 0;
      start_run(1'b1);
      for (int e = 1; e <= 15; e++) begin
         tick(1);
         n_cmp++;
         if (busy !== 1'b1 || vec_out !== 3'(e / 2)) begin
            n_fail++;
            $display("FAIL soak_edge%0d: busy=%b vec=%0d want 1 %0d", e, busy, vec_out, e / 2);
         end
      end
      tick(1);
      n_cmp++;
      if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL soak_done16: done=%b pass=%b busy=%b want 1 1 0", done, pass, busy);
      end
      tick(1);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b1 || vec_out !== 3'd0 || pass !== 1'b0) begin
         n_fail++;
         $display("FAIL soak_restart17: done=%b busy=%b vec=%b pass=%b want 0 1 000 0",
                  done, busy, vec_out, pass);
      end
      start = 1'b0;
      for (int i = 0; i < 40 && done !== 1'b1; i++) tick(1);
      n_cmp++;
      if (done !== 1'b1 || pass !== 1'b1 || err_cnt !== 4'd0) begin
         n_fail++;
         $display("FAIL soak_second_run: done=%b pass=%b err=%0d want 1 1 0", done, pass, err_cnt);
      end
   endtask

   task automatic test_x_response;
      logic probe;
      probe = 1'bx;
      // Only meaningful on a four-state simulator; two-state builds cannot carry X.
      if ($isunknown(probe)) begin
         mode = 2;
         start_run(1'b0);
         for (int i = 0; i < 40 && done !== 1'b1; i++) tick(1);
         n_cmp++;
         if (done !== 1'b1 || pass !== 1'b0 || fail_vec !== 3'd0 || fail_exp !== 1'b0 ||
             err_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL x_response: done=%b pass=%b fvec=%b fexp=%b err=%0d want 1 0 000 0 1",
                     done, pass, fail_vec, fail_exp, err_cnt);
         end
         mode = 0;
      end else begin
         $display("note: two-state simulator, X response scenario skipped");
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      test_reset;
      test_pass("pass");
      test_stuck0;
      test_reset_mid;
      test_back_to_back;
      test_x_response;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Absolute watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: time=%0t limit=200000", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
